// File: rtl/noc_axis_pkg.sv
// Shared widths, FSM state type and command record for the AXI-Stream packet source.
package noc_axis_pkg;

    localparam int unsigned TDATAW = 32;
    localparam int unsigned TDESTW = 4;
    localparam int unsigned TIDW   = 2;
    localparam int unsigned LENW   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } src_state_e;

    // One queued host command; len is beats minus one.
    typedef struct packed {
        logic [TDATAW-1:0] base;
        logic [LENW-1:0]   len;
        logic [TDESTW-1:0] dest;
        logic [TIDW-1:0]   id;
    } src_cmd_t;

endpackage

// File: rtl/axis_packet_source_if.sv
// AXI-Stream channel bundle used for both the injection (master) and return (slave) sides.
interface axis_packet_source_if;
    import noc_axis_pkg::*;

    logic              tvalid;
    logic              tready;
    logic [TDATAW-1:0] tdata;
    logic              tlast;
    logic [TIDW-1:0]   tid;
    logic [TDESTW-1:0] tdest;

    modport master (
        output tvalid,
        input  tready,
        output tdata,
        output tlast,
        output tid,
        output tdest
    );

    modport slave (
        input  tvalid,
        output tready,
        input  tdata,
        input  tlast,
        input  tid,
        input  tdest
    );

endinterface

// File: rtl/axis_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one wrap bit to tell full from empty.
module axis_cmd_fifo
    import noc_axis_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  src_cmd_t data_i,
    input  logic     pop_i,
    output src_cmd_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    src_cmd_t      mem_q [FIFO_DEPTH];
    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    // Advance pointers on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
    end

    // Pointer state; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/axis_packet_source.sv
// NoC injection endpoint: queues host commands and emits incrementing-data AXI-Stream packets,
// while sinking return traffic and counting TLAST responses.
// Optional build macro SRC_THROTTLE_EN inserts GAP_CYCLES idle cycles after each packet.
module axis_packet_source
    import noc_axis_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNTW       = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 done_o,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [TDATAW-1:0]    cmd_base_i,
    input  logic [LENW-1:0]      cmd_len_i,
    input  logic [TDESTW-1:0]    cmd_dest_i,
    input  logic [TIDW-1:0]      cmd_id_i,
    axis_packet_source_if.master axis_m_io,
    axis_packet_source_if.slave  axis_s_io,
    output logic [CNTW-1:0]      resp_cnt_o
);

    src_state_e      state_q, state_d;
    src_cmd_t        cmd_q, cmd_d;
    logic [LENW-1:0] beat_q, beat_d;
    logic            tvalid_q, tvalid_d;
    logic            done_q, done_d;
    logic            live_q;
    logic [CNTW-1:0] resp_cnt_q;
    src_cmd_t        fifo_wdata, fifo_rdata;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic            unused_s;

`ifdef SRC_THROTTLE_EN
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GapW-1:0] gap_q, gap_d;
    // Return payload is sunk unread.
    assign unused_s = ^{axis_s_io.tdata, axis_s_io.tid, axis_s_io.tdest};
`else
    // Return payload is sunk unread; the gap length only matters with throttling.
    assign unused_s = ^{axis_s_io.tdata, axis_s_io.tid, axis_s_io.tdest, 32'(GAP_CYCLES)};
`endif

    // live_q keeps both ready outputs low until the first clock after reset release.
    assign cmd_ready_o = live_q && !fifo_full;

    assign fifo_wdata.base = cmd_base_i;
    assign fifo_wdata.len  = cmd_len_i;
    assign fifo_wdata.dest = cmd_dest_i;
    assign fifo_wdata.id   = cmd_id_i;

    axis_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (cmd_valid_i && cmd_ready_o),
        .data_i (fifo_wdata),
        .pop_i  (fifo_pop),
        .data_o (fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Payload is derived from registered state only, so it holds steady through stalls.
    assign axis_m_io.tvalid = tvalid_q;
    assign axis_m_io.tdata  = cmd_q.base + TDATAW'(beat_q);
    assign axis_m_io.tlast  = tvalid_q && (beat_q == cmd_q.len);
    assign axis_m_io.tid    = cmd_q.id;
    assign axis_m_io.tdest  = cmd_q.dest;
    assign axis_s_io.tready = live_q;
    assign done_o           = done_q;
    assign resp_cnt_o       = resp_cnt_q;

    // Packet FSM next-state: load a command, walk its beats, then rest.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        beat_d   = beat_q;
        tvalid_d = tvalid_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
`ifdef SRC_THROTTLE_EN
        gap_d    = gap_q;
`endif
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rdata;
                    beat_d   = '0;
                    tvalid_d = 1'b1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (axis_m_io.tready) begin
                    if (beat_q == cmd_q.len) begin
                        tvalid_d = 1'b0;
                        done_d   = 1'b1;
`ifdef SRC_THROTTLE_EN
                        gap_d    = '0;
                        state_d  = StGap;
`else
                        state_d  = StIdle;
`endif
                    end else begin
                        beat_d = beat_q + LENW'(1);
                    end
                end
            end
`ifdef SRC_THROTTLE_EN
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) state_d = StIdle;
                else                                gap_d   = gap_q + GapW'(1);
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // FSM and packet registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            beat_q   <= '0;
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            beat_q   <= beat_d;
            tvalid_q <= tvalid_d;
            done_q   <= done_d;
        end
    end

`ifdef SRC_THROTTLE_EN
    // Gap cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) gap_q <= '0;
        else         gap_q <= gap_d;
    end
`endif

    // Ready enable and response counter (wraps at 2^CNTW).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q     <= 1'b0;
            resp_cnt_q <= '0;
        end else begin
            live_q <= 1'b1;
            if (axis_s_io.tvalid && live_q && axis_s_io.tlast) begin
                resp_cnt_q <= resp_cnt_q + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_source.sv
// Scoreboard bench for axis_packet_source: accepted commands expand into expected beats that a
// negedge monitor pops and compares as the master side handshakes.
module tb_axis_packet_source;
    import noc_axis_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNTW       = 16;
    localparam int unsigned GAP_CYCLES = 2;
`ifdef SRC_THROTTLE_EN
    localparam int GapModel = GAP_CYCLES;
`else
    localparam int GapModel = 0;
`endif

    typedef struct packed {
        logic [TDATAW-1:0] data;
        logic              last;
        logic [TIDW-1:0]   id;
        logic [TDESTW-1:0] dest;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              done;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [TDATAW-1:0] cmd_base = '0;
    logic [LENW-1:0]   cmd_len = '0;
    logic [TDESTW-1:0] cmd_dest = '0;
    logic [TIDW-1:0]   cmd_id = '0;
    logic [CNTW-1:0]   resp_cnt;

    axis_packet_source_if m_if ();
    axis_packet_source_if s_if ();

    axis_packet_source #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNTW      (CNTW),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .done_o     (done),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_base_i (cmd_base),
        .cmd_len_i  (cmd_len),
        .cmd_dest_i (cmd_dest),
        .cmd_id_i   (cmd_id),
        .axis_m_io  (m_if),
        .axis_s_io  (s_if),
        .resp_cnt_o (resp_cnt)
    );

    int    checks = 0;
    int    passes = 0;
    beat_t exp_q[$];
    logic [TDATAW-1:0] obs_q[$];
    int    cyc = 0;
    int    last_hs = -1000;
    int    done_seen = 0;
    int    cmds_acc = 0;
    int    rdy_mode = 0;  // 0 low, 1 high, 2 toggle, 3 random

    initial forever #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Master-side TREADY pattern generator.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                2:       m_if.tready = ~m_if.tready;
                default: m_if.tready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Scoreboard: expand accepted commands, check handshaked beats, DONE, stalls and spacing.
    initial begin
        bit    exp_done = 0, hold_v = 0, prev_tv = 0, lat_pend = 0, gap_pend = 0;
        int    lat_cyc = 0;
        beat_t hold, act, e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_ni) begin
                exp_q.delete();
                exp_done = 0; hold_v = 0; prev_tv = 0; lat_pend = 0; gap_pend = 0;
                last_hs = -1000;
            end else begin
                act = {m_if.tdata, m_if.tlast, m_if.tid, m_if.tdest};
                if (exp_done) chk(done === 1'b1, "done_pulse", 64'(done), 1);
                else if (done !== 1'b0) chk(1'b0, "done_spurious", 64'(done), 0);
                exp_done = 0;
                if (done === 1'b1) done_seen++;
                if (hold_v)
                    chk(m_if.tvalid === 1'b1 && act === hold, "stall_hold", 64'(act), 64'(hold));
                hold_v = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
                hold = act;
                if (cmd_valid && cmd_ready === 1'b1) begin
                    if (exp_q.size() == 0 && (cyc - last_hs) >= GapModel) begin
                        lat_pend = 1;
                        lat_cyc  = cyc + 2;
                    end
                    cmds_acc++;
                    for (int b = 0; b <= int'(cmd_len); b++)
                        exp_q.push_back({cmd_base + TDATAW'(b), b == int'(cmd_len), cmd_id,
                                         cmd_dest});
                end
                if (m_if.tvalid === 1'b1 && !prev_tv) begin
                    if (lat_pend) chk(cyc == lat_cyc, "first_beat_latency", cyc, lat_cyc);
                    if (gap_pend)
                        chk(cyc - last_hs - 1 == GapModel + 1, "pkt_spacing",
                            cyc - last_hs - 1, GapModel + 1);
                    lat_pend = 0;
                    gap_pend = 0;
                end
                prev_tv = (m_if.tvalid === 1'b1);
                if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", 64'(act), 0);
                    end else begin
                        e = exp_q.pop_front();
                        obs_q.push_back(m_if.tdata);
                        chk(act === e, "beat", 64'(act), 64'(e));
                        if (e.last) begin
                            last_hs  = cyc;
                            exp_done = 1;
                            gap_pend = (exp_q.size() > 0);
                        end
                    end
                end
            end
        end
    end

    task automatic push_cmd(input src_cmd_t c, input int max_wait, output bit ok);
        cmd_valid = 1'b1;
        cmd_base  = c.base;
        cmd_len   = c.len;
        cmd_dest  = c.dest;
        cmd_id    = c.id;
        ok = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) ok = 1;
            tick();
            if (ok) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && m_if.tvalid !== 1'b1) begin
                ok = 1;
                break;
            end
        end
        repeat (4) tick();
        chk(ok, name, exp_q.size(), 0);
    endtask

    initial begin
        src_cmd_t c;
        bit       ok;
        int       acc, nfail, d0;

        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(m_if.tvalid === 1'b0, "rst_tvalid", 64'(m_if.tvalid), 0);
        chk(m_if.tlast === 1'b0, "rst_tlast", 64'(m_if.tlast), 0);
        chk(m_if.tdata === '0 && m_if.tid === '0 && m_if.tdest === '0, "rst_payload",
            64'(m_if.tdata), 0);
        chk(done === 1'b0, "rst_done", 64'(done), 0);
        chk(cmd_ready === 1'b0, "rst_cmd_ready", 64'(cmd_ready), 0);
        chk(s_if.tready === 1'b0, "rst_s_tready", 64'(s_if.tready), 0);
        chk(resp_cnt === '0, "rst_resp_cnt", 64'(resp_cnt), 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        tick();
        @(negedge clk);
        chk(s_if.tready === 1'b1, "s_tready_up", 64'(s_if.tready), 1);
        chk(cmd_ready === 1'b1, "cmd_ready_up", 64'(cmd_ready), 1);
        tick();

        // Single packet, sink always ready.
        rdy_mode = 1;
        d0 = done_seen;
        c = '{base: 32'h10, len: 4'd3, dest: 4'd2, id: 2'd1};
        push_cmd(c, 10, ok);
        chk(ok, "push_basic", 64'(ok), 1);
        wait_drain(50, "drain_basic");
        chk(done_seen == d0 + 1, "done_count_basic", done_seen, d0 + 1);

        // Same packet under alternating back-pressure.
        rdy_mode = 2;
        push_cmd(c, 10, ok);
        wait_drain(50, "drain_toggle");

        // Fill: one command moves into the send registers, FIFO_DEPTH more fill the queue.
        rdy_mode = 0;
        repeat (3) tick();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            c = '{base: 32'(32'h100 * (i + 1)), len: 4'd1, dest: 4'(i), id: 2'(i)};
            push_cmd(c, 1, ok);
            if (ok) acc++;
        end
        chk(acc == 5, "fill_accepted", acc, 5);
        c = '{base: 32'h600, len: 4'd0, dest: 4'd6, id: 2'd2};
        push_cmd(c, 6, ok);
        chk(!ok, "full_blocks_push", 64'(ok), 0);
        rdy_mode = 1;
        push_cmd(c, 200, ok);
        chk(ok, "push_after_pop", 64'(ok), 1);
        wait_drain(300, "drain_fill");

        // Data wrap across 2^TDATAW.
        obs_q.delete();
        c = '{base: 32'hFFFF_FFFE, len: 4'd2, dest: 4'd9, id: 2'd3};
        push_cmd(c, 10, ok);
        wait_drain(50, "drain_wrap");
        chk(obs_q.size() == 3, "wrap_beats", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk(obs_q[0] == 32'hFFFF_FFFE, "wrap_b0", 64'(obs_q[0]), 64'h FFFF_FFFE);
            chk(obs_q[1] == 32'hFFFF_FFFF, "wrap_b1", 64'(obs_q[1]), 64'h FFFF_FFFF);
            chk(obs_q[2] == 32'h0, "wrap_b2", 64'(obs_q[2]), 0);
        end

        // Back-to-back minimum and maximum length packets.
        c = '{base: 32'h7000, len: 4'd0, dest: 4'd1, id: 2'd0};
        push_cmd(c, 10, ok);
        c = '{base: 32'h8000, len: 4'd15, dest: 4'd15, id: 2'd3};
        push_cmd(c, 10, ok);
        wait_drain(100, "drain_b2b");

        // Randomized commands and back-pressure.
        rdy_mode = 3;
        nfail = 0;
        for (int i = 0; i < 40; i++) begin
            c.base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                 : 32'($urandom);
            c.len  = 4'($urandom_range(0, 15));
            c.dest = 4'($urandom);
            c.id   = 2'($urandom);
            push_cmd(c, 300, ok);
            if (!ok) nfail++;
            repeat ($urandom_range(0, 3)) tick();
        end
        chk(nfail == 0, "rand_push", nfail, 0);
        wait_drain(2000, "drain_rand");
        chk(done_seen == cmds_acc, "done_per_packet", done_seen, cmds_acc);

        // Return traffic: three 2-beat packets, then wrap the counter.
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_if.tlast = i[0];
            s_if.tdata = 32'($urandom);
            tick();
        end
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk(resp_cnt === 16'd3, "resp_cnt_3", 64'(resp_cnt), 3);
        tick();
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b1;
        repeat (65532) tick();
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk(resp_cnt === 16'hFFFF, "resp_cnt_max", 64'(resp_cnt), 64'hFFFF);
        tick();
        s_if.tvalid = 1'b1;
        tick();
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk(resp_cnt === 16'h0, "resp_cnt_wrap", 64'(resp_cnt), 0);
        tick();

        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        // Reset in the middle of a packet with a second command queued.
        rdy_mode = 1;
        c = '{base: 32'h500, len: 4'd3, dest: 4'd4, id: 2'd2};
        push_cmd(c, 10, ok);
        c = '{base: 32'h900, len: 4'd1, dest: 4'd5, id: 2'd1};
        push_cmd(c, 10, ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_if.tvalid === 1'b1 && m_if.tdata === 32'h502) begin
                ok = 1;
                break;
            end
        end
        chk(ok, "reach_beat2", 64'(ok), 1);
        #1 rst_ni = 1'b0;
        #1;
        chk(m_if.tvalid === 1'b0, "midrst_tvalid", 64'(m_if.tvalid), 0);
        chk(cmd_ready === 1'b0 && s_if.tready === 1'b0, "midrst_ready",
            64'({cmd_ready, s_if.tready}), 0);
        chk(done === 1'b0 && resp_cnt === '0, "midrst_outputs", 64'({done, resp_cnt}), 0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        ok = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_if.tvalid !== 1'b0) ok = 0;
        end
        chk(ok, "fifo_flushed", 64'(ok), 1);
        chk(cmd_ready === 1'b1, "ready_after_rst", 64'(cmd_ready), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
